// File: rtl/i2s_rx_if.sv
// I2S receiver bus: serial pins and enable in, captured stereo words and error status out.
interface i2s_rx_if #(
  parameter int DATA_BITS = 16
);
  logic                 enable;
  logic                 i2s_sclk;
  logic                 i2s_lrck;
  logic                 i2s_sdata;
  logic [DATA_BITS-1:0] sample_l;
  logic [DATA_BITS-1:0] sample_r;
  logic                 sample_valid;
  logic                 frame_err;
  logic [7:0]           err_count;

  modport master (
    output enable, i2s_sclk, i2s_lrck, i2s_sdata,
    input  sample_l, sample_r, sample_valid, frame_err, err_count
  );

  modport slave (
    input  enable, i2s_sclk, i2s_lrck, i2s_sdata,
    output sample_l, sample_r, sample_valid, frame_err, err_count
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples sclk/lrck/sdata in the clk domain, deserializes
// left/right words, publishes complete stereo pairs and flags slot-length errors.
module i2s_rx #(
  parameter int DATA_BITS = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic    clk,
  input  logic    reset_n,
  i2s_rx_if.slave bus
);

  localparam logic [5:0] LAST_DATA = 6'(DATA_BITS - 1);
  localparam logic [5:0] LAST_EDGE = 6'(SLOT_BITS - 1);
  localparam logic [5:0] NUM_DATA  = 6'(DATA_BITS);

  typedef enum logic {ST_IDLE, ST_ARMED} state_t;

  state_t               state, state_nxt;
  logic [1:0]           sclk_sync, lrck_sync, sdata_sync;
  logic                 sclk_d, lrck_prev, chan;
  logic [5:0]           edge_cnt;
  logic [DATA_BITS-1:0] shreg, hold_l, hold_r, word;
  logic                 complete, left_ok, pair_q, err_q;
  logic                 sclk_rise, slot_change, armed, word_done, len_bad;

  // All three pins share the same two-flop depth so data stays aligned to its clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      sclk_d     <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], bus.i2s_sclk};
      lrck_sync  <= {lrck_sync[0], bus.i2s_lrck};
      sdata_sync <= {sdata_sync[0], bus.i2s_sdata};
      sclk_d     <= sclk_sync[1];
    end
  end

  assign sclk_rise   = sclk_sync[1] & ~sclk_d;
  assign slot_change = sclk_rise & (lrck_sync[1] != lrck_prev);
  assign armed       = (state == ST_ARMED);
  assign word        = {shreg[DATA_BITS-2:0], sdata_sync[1]};
  assign word_done   = bus.enable & sclk_rise & ~slot_change & armed & (edge_cnt == LAST_DATA);
  assign len_bad     = bus.enable & slot_change & armed & (edge_cnt != LAST_EDGE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Arming waits for a slot boundary so a partially observed slot is never used.
  always_comb begin
    state_nxt = state;
    if (!bus.enable)                         state_nxt = ST_IDLE;
    else if (state == ST_IDLE && slot_change) state_nxt = ST_ARMED;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrck_prev <= 1'b0;
      chan      <= 1'b0;
      edge_cnt  <= '0;
      shreg     <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
      complete  <= 1'b0;
      left_ok   <= 1'b0;
      pair_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pair_q <= word_done & chan & left_ok;
      err_q  <= len_bad;
      if (sclk_rise) lrck_prev <= lrck_sync[1];
      if (!bus.enable) begin
        edge_cnt <= '0;
        left_ok  <= 1'b0;
        complete <= 1'b0;
      end else if (slot_change) begin
        // The bit on a word-select change belongs to the previous word's delay slot.
        edge_cnt <= '0;
        chan     <= lrck_sync[1];
        complete <= 1'b0;
        left_ok  <= lrck_sync[1] & ~chan & armed & complete & (edge_cnt == LAST_EDGE);
      end else if (sclk_rise) begin
        if (edge_cnt != 6'h3F)     edge_cnt <= edge_cnt + 6'd1;
        if (edge_cnt < NUM_DATA)   shreg    <= word;
        if (word_done) begin
          complete <= 1'b1;
          if (chan) hold_r <= word;
          else      hold_l <= word;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.sample_l     <= '0;
      bus.sample_r     <= '0;
      bus.sample_valid <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.err_count    <= '0;
    end else begin
      bus.sample_valid <= pair_q & bus.enable;
      bus.frame_err    <= err_q & bus.enable;
      if (pair_q & bus.enable) begin
        bus.sample_l <= hold_l;
        bus.sample_r <= hold_r;
      end
      if (err_q & bus.enable & (bus.err_count != 8'hFF))
        bus.err_count <= bus.err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboarded bench for i2s_rx: drives an I2S stream, expects pairs in a queue and
// checks sample values, pin-to-valid latency, error pulses and saturation.
`timescale 1ns/1ps
module tb_i2s_rx;

  localparam int      DB   = 16;
  localparam realtime TCLK = 13.468;

  typedef struct packed {
    logic [DB-1:0] l;
    logic [DB-1:0] r;
  } pair_t;

  logic    clk = 1'b0;
  logic    reset_n = 1'b0;
  pair_t   sb[$];
  pair_t   want;
  int      n_checks = 0, n_pass = 0;
  int      valid_cnt = 0, err_pulses = 0, cyc = 0, last_valid_cyc = 0, last_interval = 0;
  realtime sclk_half = 162.760;
  realtime t_r16 = 0.0;
  realtime dly;
  logic [DB-1:0] last_l = '0, last_r = '0;

  i2s_rx_if #(.DATA_BITS(DB)) bus();

  i2s_rx #(.DATA_BITS(DB), .SLOT_BITS(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #(TCLK/2) clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every valid must match the oldest expected pair, 4 clk after its edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.frame_err) err_pulses++;
    if (bus.sample_valid) begin
      valid_cnt++;
      last_interval  = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: got l=%h r=%h, expected no pulse", bus.sample_l, bus.sample_r);
      end else begin
        want = sb.pop_front();
        if (bus.sample_l !== want.l || bus.sample_r !== want.r)
          $display("FAIL pair_data: got l=%h r=%h, expected l=%h r=%h",
                   bus.sample_l, bus.sample_r, want.l, want.r);
        else n_pass++;
        last_l = want.l;
        last_r = want.r;
        n_checks++;
        dly = $realtime - t_r16;
        if (dly < 3.0*TCLK + 0.5 || dly > 4.0*TCLK + 1.5)
          $display("FAIL latency: got %0.3f ns, expected within (%0.3f, %0.3f]", dly, 3.0*TCLK, 4.0*TCLK);
        else n_pass++;
      end
    end
  end

  task automatic sclk_bit(input logic lr, input logic d, input logic mark);
    bus.i2s_lrck  = lr;
    bus.i2s_sdata = d;
    #(sclk_half);
    bus.i2s_sclk = 1'b1;
    if (mark) t_r16 = $realtime;
    #(sclk_half);
    bus.i2s_sclk = 1'b0;
  endtask

  // Edge 0 carries the lrck change, edges 1..DB the word MSB first, the rest zero padding.
  task automatic send_slot(input logic ch, input logic [DB-1:0] w, input int e0, input int n);
    int bi;
    for (int e = e0; e < n; e++) begin
      bi = DB - e;
      if (e >= 1 && e <= DB) sclk_bit(ch, w[bi[3:0]], ch && (e == DB));
      else                   sclk_bit(ch, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] l, input logic [DB-1:0] r, input bit expect_valid);
    if (expect_valid) sb.push_back({l, r});
    send_slot(1'b0, l, 0, 32);
    send_slot(1'b1, r, 0, 32);
  endtask

  task automatic test_reset;
    bus.enable = 1'b1; bus.i2s_sclk = 1'b0; bus.i2s_lrck = 1'b0; bus.i2s_sdata = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({bus.sample_l, bus.sample_r} !== '0)
      $display("FAIL reset_samples: got %h/%h, expected 0/0", bus.sample_l, bus.sample_r);
    else n_pass++;
    n_checks++;
    if ({bus.sample_valid, bus.frame_err} !== 2'b00)
      $display("FAIL reset_flags: got %b%b, expected 00", bus.sample_valid, bus.frame_err);
    else n_pass++;
    n_checks++;
    if (bus.err_count !== 8'd0) $display("FAIL reset_err_count: got %0d, expected 0", bus.err_count);
    else n_pass++;
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_stereo;
    int v0;
    sclk_half = 162.760;
    send_frame(16'hA5C3, 16'h5A3C, 1'b0);   // arming frame
    v0 = valid_cnt;
    repeat (3) send_frame(16'hA5C3, 16'h5A3C, 1'b1);
    n_checks++;
    if (valid_cnt - v0 != 3) $display("FAIL stereo_valid_count: got %0d, expected 3", valid_cnt - v0);
    else n_pass++;
    n_checks++;
    if (bus.err_count !== 8'd0) $display("FAIL stereo_err_count: got %0d, expected 0", bus.err_count);
    else n_pass++;
  endtask

  task automatic test_silence;
    for (int f = 0; f < 3; f++) begin
      send_frame(16'h0000, 16'h0000, 1'b1);
      n_checks++;
      if (last_interval != 1546 && last_interval != 1547)
        $display("FAIL silence_interval: got %0d clk, expected 1546 or 1547", last_interval);
      else n_pass++;
    end
    n_checks++;
    if (bus.err_count !== 8'd0) $display("FAIL silence_err_count: got %0d, expected 0", bus.err_count);
    else n_pass++;
  endtask

  task automatic test_patterns;
    int v0;
    sclk_half = 60.0;
    v0 = valid_cnt;
    for (int f = 0; f < 4; f++)
      send_frame(16'($urandom), 16'($urandom), 1'b1);
    n_checks++;
    if (valid_cnt - v0 != 4) $display("FAIL pattern_valid_count: got %0d, expected 4", valid_cnt - v0);
    else n_pass++;
  endtask

  task automatic test_short_left;
    int v0, e0;
    v0 = valid_cnt; e0 = err_pulses;
    send_slot(1'b0, 16'h1234, 0, 30);
    send_slot(1'b1, 16'h4321, 0, 32);
    send_frame(16'hBEEF, 16'hCAFE, 1'b1);
    n_checks++;
    if (err_pulses - e0 != 1) $display("FAIL short_err_pulses: got %0d, expected 1", err_pulses - e0);
    else n_pass++;
    n_checks++;
    if (bus.err_count !== 8'd1) $display("FAIL short_err_count: got %0d, expected 1", bus.err_count);
    else n_pass++;
    n_checks++;
    if (valid_cnt - v0 != 1) $display("FAIL short_valid_count: got %0d, expected 1", valid_cnt - v0);
    else n_pass++;
  endtask

  task automatic test_enable;
    int v0, e0;
    logic [7:0] ec0;
    v0 = valid_cnt; e0 = err_pulses; ec0 = bus.err_count;
    send_slot(1'b0, 16'h1111, 0, 32);
    bus.enable = 1'b0;
    send_slot(1'b1, 16'h2222, 0, 29);       // bad length while disabled must not count
    repeat (3) send_frame(16'h3333, 16'h4444, 1'b0);
    send_slot(1'b0, 16'h5555, 0, 32);
    n_checks++;
    if (valid_cnt != v0 || err_pulses != e0)
      $display("FAIL disabled_pulses: got valid=%0d err=%0d, expected 0/0", valid_cnt - v0, err_pulses - e0);
    else n_pass++;
    n_checks++;
    if (bus.err_count !== ec0 || bus.sample_l !== last_l || bus.sample_r !== last_r)
      $display("FAIL disabled_hold: got cnt=%0d l=%h r=%h, expected cnt=%0d l=%h r=%h",
               bus.err_count, bus.sample_l, bus.sample_r, ec0, last_l, last_r);
    else n_pass++;
    bus.enable = 1'b1;
    send_slot(1'b1, 16'h6666, 0, 32);       // arming slot, no pair yet
    send_frame(16'h7E57, 16'h0DD5, 1'b1);
    n_checks++;
    if (valid_cnt - v0 != 1) $display("FAIL reenable_valid_count: got %0d, expected 1", valid_cnt - v0);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int v0;
    send_slot(1'b0, 16'h7777, 0, 10);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.sample_l, bus.sample_r, bus.sample_valid, bus.frame_err, bus.err_count} !== '0)
      $display("FAIL midreset_outputs: got l=%h r=%h v=%b e=%b cnt=%0d, expected all 0",
               bus.sample_l, bus.sample_r, bus.sample_valid, bus.frame_err, bus.err_count);
    else n_pass++;
    last_l = '0; last_r = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    v0 = valid_cnt;
    send_slot(1'b0, 16'h7777, 10, 32);
    send_slot(1'b1, 16'h8888, 0, 32);
    n_checks++;
    if (valid_cnt != v0 || bus.sample_l !== 16'h0)
      $display("FAIL midreset_early_valid: got %0d pulses l=%h, expected 0 pulses l=0000", valid_cnt - v0, bus.sample_l);
    else n_pass++;
    send_frame(16'h9999, 16'hAAAA, 1'b1);
    n_checks++;
    if (valid_cnt - v0 != 1) $display("FAIL midreset_valid_count: got %0d, expected 1", valid_cnt - v0);
    else n_pass++;
  endtask

  task automatic test_saturate;
    int e0;
    sclk_half = 28.0;
    e0 = err_pulses;
    for (int i = 0; i < 300; i++) send_slot(1'(i % 2), 16'h0F0F, 0, 31);
    repeat (6) @(posedge clk);
    n_checks++;
    if (bus.err_count !== 8'd255) $display("FAIL sat_err_count: got %0d, expected 255", bus.err_count);
    else n_pass++;
    n_checks++;
    if (err_pulses - e0 != 299) $display("FAIL sat_err_pulses: got %0d, expected 299", err_pulses - e0);
    else n_pass++;
    send_slot(1'b0, 16'h0F0F, 0, 31);
    send_slot(1'b1, 16'h0F0F, 0, 31);
    repeat (6) @(posedge clk);
    n_checks++;
    if (bus.err_count !== 8'd255 || err_pulses - e0 != 301)
      $display("FAIL sat_hold: got cnt=%0d pulses=%0d, expected 255/301", bus.err_count, err_pulses - e0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stereo();
    test_silence();
    test_patterns();
    test_short_left();
    test_enable();
    test_mid_reset();
    test_saturate();
    repeat (10) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
